ram_access_arbiter: RTL



---
 rtl/ram_access_arbiter_pkg.sv | 29 ++
 rtl/ram_access_arbiter_if.sv | 35 +++
 rtl/ram_access_arbiter_rr_arb2.sv | 36 +++
 rtl/ram_access_arbiter.sv | 112 +++++++++++
 4 files changed

// File: rtl/ram_access_arbiter_pkg.sv
// Shared types and constants for the RAM access arbiter and its round-robin helper.
package ram_access_arbiter_pkg;

  // Ceiling log2; callers guarantee value >= 2 so the result is never 0.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StAccess   = 2'd1,
    StComplete = 2'd2
  } state_t;

  localparam logic ReqId0 = 1'b0;
  localparam logic ReqId1 = 1'b1;

  // Wide enough for access_cycles - 1 with access_cycles up to 15.
  localparam int unsigned CountWidth = 4;

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Requester-side handshake bundle for both clients of the RAM access arbiter.
interface ram_access_arbiter_if #(
  parameter int unsigned data_width = 8,
  parameter int unsigned addr_width = 8
);
  logic                  req0;
  logic                  we0;
  logic [addr_width-1:0] addr0;
  logic [data_width-1:0] wdata0;
  logic                  ack0;
  logic [data_width-1:0] rdata0;

  logic                  req1;
  logic                  we1;
  logic [addr_width-1:0] addr1;
  logic [data_width-1:0] wdata1;
  logic                  ack1;
  logic [data_width-1:0] rdata1;

  // Requester side.
  modport master (
    output req0, we0, addr0, wdata0,
    input  ack0, rdata0,
    output req1, we1, addr1, wdata1,
    input  ack1, rdata1
  );

  // Arbiter side.
  modport slave (
    input  req0, we0, addr0, wdata0,
    output ack0, rdata0,
    input  req1, we1, addr1, wdata1,
    output ack1, rdata1
  );
endinterface

// File: rtl/ram_access_arbiter_rr_arb2.sv
// Two-way round-robin grant: combinational pick, pointer advances past the served requester.
module rr_arb2
  import ram_access_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served,
  output logic       valid,
  output logic       grant
);

  logic pointer;

  // Pointer favours the requester that was not served last.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pointer <= ReqId0;
    end else if (update) begin
      pointer <= ~served;
    end
  end

  // A lone request wins outright; a tie goes to the pointer.
  always_comb begin
    valid = |req;
    grant = ReqId0;
    if (req == 2'b11) begin
      grant = pointer;
    end else if (req[1]) begin
      grant = ReqId1;
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one single-port RAM between two requesters with a fixed-length access sequence.
module ram_access_arbiter
  import ram_access_arbiter_pkg::*;
#(
  parameter int unsigned data_width    = 8,
  parameter int unsigned ram_depth     = 256,
  parameter int unsigned access_cycles = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  ram_access_arbiter_if.slave            bus,
  output logic [clogb2(ram_depth)-1:0]   ram_address,
  output logic                           ram_write,
  output logic                           ram_chip_select,
  inout  wire  [data_width-1:0]          ram_data
);

  localparam int unsigned addr_width = clogb2(ram_depth);

  state_t                        state;
  logic                          winner;
  logic                          lat_we;
  logic [data_width-1:0]         lat_wdata;
  logic [CountWidth-1:0]         count;
  logic                          drive;
  logic [1:0]                    ack;
  logic [1:0][data_width-1:0]    rdata;

  logic grant_valid;
  logic grant_id;

  rr_arb2 u_rr_arb2 (
    .clock  (clock),
    .reset  (reset),
    .req    ({bus.req1, bus.req0}),
    .update (state == StComplete),
    .served (winner),
    .valid  (grant_valid),
    .grant  (grant_id)
  );

  // Bus is only driven by a registered enable, so it never glitches on outside of a write.
  assign ram_data = drive ? lat_wdata : {data_width{1'bz}};

  assign bus.ack0   = ack[0];
  assign bus.ack1   = ack[1];
  assign bus.rdata0 = rdata[0];
  assign bus.rdata1 = rdata[1];

  // Access sequencer: latch the winner, hold chip select for access_cycles, then ack.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= StIdle;
      winner          <= ReqId0;
      lat_we          <= 1'b0;
      lat_wdata       <= '0;
      count           <= '0;
      drive           <= 1'b0;
      ack             <= '0;
      rdata           <= '0;
      ram_address     <= '0;
      ram_write       <= 1'b0;
      ram_chip_select <= 1'b0;
    end else begin
      ack <= '0;
      unique case (state)
        StIdle: begin
          if (grant_valid) begin
            winner          <= grant_id;
            state           <= StAccess;
            count           <= CountWidth'(access_cycles - 1);
            ram_chip_select <= 1'b1;
            if (grant_id == ReqId1) begin
              lat_we      <= bus.we1;
              lat_wdata   <= bus.wdata1;
              ram_address <= addr_width'(bus.addr1);
              ram_write   <= bus.we1;
              drive       <= bus.we1;
            end else begin
              lat_we      <= bus.we0;
              lat_wdata   <= bus.wdata0;
              ram_address <= addr_width'(bus.addr0);
              ram_write   <= bus.we0;
              drive       <= bus.we0;
            end
          end
        end
        StAccess: begin
          if (count == '0) begin
            state           <= StComplete;
            ram_chip_select <= 1'b0;
            ram_write       <= 1'b0;
            drive           <= 1'b0;
            ack[winner]     <= 1'b1;
            if (!lat_we) begin
              rdata[winner] <= ram_data;
            end
          end else begin
            count <= count - 1'b1;
          end
        end
        StComplete: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
